// File: rtl/ntsc_timing_sequencer.sv
// ---------------------------------------------------------------------------
// ntsc_timing_sequencer
//
// Purpose:
//   Dot/line sequencer for an NES-style NTSC composite video generator. It
//   counts dots (0..DOTS_PER_LINE-1) and lines (0..LINES_PER_FRAME-1). It
//   decodes the horizontal and vertical position into the per-dot generator
//   strobes. It also selects the colour (picture, border backdrop or black)
//   and the emphasis bits for the generator.
//
//   The vertical blanking layout is placed relative to ACTIVE_LINES:
//     ACTIVE_LINES+0 .. +3  blank (post-render)
//     ACTIVE_LINES+4 .. +6  vsync (serrated over the hsync dot range)
//     ACTIVE_LINES+7 .. end blank (pre-render)
//   vblank_start fires at line ACTIVE_LINES+1, dot 1.
//   The defaults give the NES layout: blank 240-243, vsync 244-246,
//   blank 247-261, vblank at line 241.
//
// Ports:
//   clock            system clock (doubled clock domain)
//   reset            synchronous, active-high; wins over dot_EN
//   dot_EN           one-cycle dot pulse; all state advances only when high
//   render_EN        rendering enabled; gates the odd-frame short line
//   picture_colour   renderer palette index for the current pixel
//   backdrop_colour  palette index used on border dots
//   emphasis_in      colour emphasis bits
//   sync_EN, colorBurst_EN, luminance_EN, chrominance_EN
//                    registered per-dot generator strobes
//   pixelColour      registered palette index to the generator
//   emphasis         registered emphasis bits to the generator
//   pixel_x/pixel_y  registered dot/line counters for the dot being output
//   pixel_valid      dot lies inside the 256x240 picture
//   vblank_start     one-dot pulse at the start of vertical blanking
//   frame_odd        frame parity
// ---------------------------------------------------------------------------
module ntsc_timing_sequencer #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int ACTIVE_LINES    = 240,
  parameter int ODD_SKIP_EN     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dot_EN,
  input  logic       render_EN,
  input  logic [5:0] picture_colour,
  input  logic [5:0] backdrop_colour,
  input  logic [2:0] emphasis_in,
  output logic       sync_EN,
  output logic       colorBurst_EN,
  output logic       luminance_EN,
  output logic       chrominance_EN,
  output logic [5:0] pixelColour,
  output logic [2:0] emphasis,
  output logic [8:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       pixel_valid,
  output logic       vblank_start,
  output logic       frame_odd
);

  // Counter limits
  localparam logic [8:0] LP_DOT_LAST    = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LP_SKIP_DOT    = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LP_LINE_LAST   = 9'(LINES_PER_FRAME - 1);

  // Vertical layout
  localparam logic [8:0] LP_ACTIVE      = 9'(ACTIVE_LINES);
  localparam logic [8:0] LP_VBLANK_LINE = 9'(ACTIVE_LINES + 1);
  localparam logic [8:0] LP_VSYNC_FIRST = 9'(ACTIVE_LINES + 4);
  localparam logic [8:0] LP_VSYNC_LAST  = 9'(ACTIVE_LINES + 6);

  // Horizontal layout (dot numbers)
  localparam logic [8:0] LP_PIC_LAST      = 9'd255;
  localparam logic [8:0] LP_RBORDER_FIRST = 9'd256;
  localparam logic [8:0] LP_RBORDER_LAST  = 9'd266;
  localparam logic [8:0] LP_HSYNC_FIRST   = 9'd276;
  localparam logic [8:0] LP_HSYNC_LAST    = 9'd300;
  localparam logic [8:0] LP_BURST_FIRST   = 9'd305;
  localparam logic [8:0] LP_BURST_LAST    = 9'd319;
  localparam logic [8:0] LP_LBORDER_FIRST = 9'd326;

  // Position state
  logic [8:0] r_dot;
  logic [8:0] r_line;
  logic       r_frame_odd;

  // Registered generator outputs
  logic       r_sync;
  logic       r_burst;
  logic       r_lum;
  logic       r_chr;
  logic [5:0] r_colour;
  logic [2:0] r_emph;
  logic       r_valid;
  logic       r_vblank;

  // Next position
  logic       w_skip;
  logic [8:0] w_next_dot;
  logic [8:0] w_next_line;
  logic       w_next_odd;

  // Decode of the next position
  logic       w_pic_dot;
  logic       w_border_dot;
  logic       w_hsync_dot;
  logic       w_burst_dot;
  logic       w_pic_line;
  logic       w_vsync_line;
  logic       w_sync;
  logic       w_burst;
  logic       w_lum;
  logic       w_chr;
  logic [5:0] w_colour;
  logic [2:0] w_emph;
  logic       w_valid;
  logic       w_vblank;

  // Next dot/line/parity. The short odd frame drops the last dot of the
  // final line, so dot DOTS_PER_LINE-2 wraps straight to the next frame.
  always_comb begin
    w_skip = (ODD_SKIP_EN != 0) && render_EN && r_frame_odd &&
             (r_line == LP_LINE_LAST) && (r_dot == LP_SKIP_DOT);
    w_next_dot  = r_dot + 9'd1;
    w_next_line = r_line;
    w_next_odd  = r_frame_odd;
    if (w_skip || (r_dot == LP_DOT_LAST)) begin
      w_next_dot = 9'd0;
      if (w_skip || (r_line == LP_LINE_LAST)) begin
        w_next_line = 9'd0;
        w_next_odd  = ~r_frame_odd;
      end else begin
        w_next_line = r_line + 9'd1;
      end
    end else begin
      w_next_dot = r_dot + 9'd1;
    end
  end

  // Region and strobe decode for the position about to be output
  always_comb begin
    w_pic_dot    = (w_next_dot <= LP_PIC_LAST);
    w_border_dot = ((w_next_dot >= LP_RBORDER_FIRST) && (w_next_dot <= LP_RBORDER_LAST)) ||
                   (w_next_dot >= LP_LBORDER_FIRST);
    w_hsync_dot  = (w_next_dot >= LP_HSYNC_FIRST) && (w_next_dot <= LP_HSYNC_LAST);
    w_burst_dot  = (w_next_dot >= LP_BURST_FIRST) && (w_next_dot <= LP_BURST_LAST);
    w_pic_line   = (w_next_line < LP_ACTIVE);
    w_vsync_line = (w_next_line >= LP_VSYNC_FIRST) && (w_next_line <= LP_VSYNC_LAST);

    w_sync   = 1'b0;
    w_burst  = 1'b0;
    w_lum    = 1'b0;
    w_chr    = 1'b0;
    w_colour = 6'd0;
    w_emph   = 3'd0;
    w_valid  = 1'b0;

    if (w_vsync_line) begin
      // Vsync lines are sync level throughout, with serration pulses
      // (black level) over the normal hsync window.
      w_sync = ~w_hsync_dot;
    end else if (w_pic_line && (w_pic_dot || w_border_dot)) begin
      w_lum    = 1'b1;
      w_chr    = 1'b1;
      w_colour = w_pic_dot ? picture_colour : backdrop_colour;
      w_emph   = emphasis_in;
      w_valid  = w_pic_dot;
    end else if (w_hsync_dot) begin
      w_sync = 1'b1;
    end else if (w_burst_dot) begin
      w_burst = 1'b1;
    end else begin
      // Porches, breezeway, pulse and blank-line picture/border: black level
      w_sync = 1'b0;
    end

    w_vblank = (w_next_line == LP_VBLANK_LINE) && (w_next_dot == 9'd1);
  end

  // Position counters and registered outputs; advance only on dot_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dot       <= 9'd0;
      r_line      <= 9'd0;
      r_frame_odd <= 1'b0;
      r_sync      <= 1'b0;
      r_burst     <= 1'b0;
      r_lum       <= 1'b0;
      r_chr       <= 1'b0;
      r_colour    <= 6'd0;
      r_emph      <= 3'd0;
      r_valid     <= 1'b0;
      r_vblank    <= 1'b0;
    end else if (dot_EN) begin
      r_dot       <= w_next_dot;
      r_line      <= w_next_line;
      r_frame_odd <= w_next_odd;
      r_sync      <= w_sync;
      r_burst     <= w_burst;
      r_lum       <= w_lum;
      r_chr       <= w_chr;
      r_colour    <= w_colour;
      r_emph      <= w_emph;
      r_valid     <= w_valid;
      r_vblank    <= w_vblank;
    end
  end

  assign sync_EN        = r_sync;
  assign colorBurst_EN  = r_burst;
  assign luminance_EN   = r_lum;
  assign chrominance_EN = r_chr;
  assign pixelColour    = r_colour;
  assign emphasis       = r_emph;
  assign pixel_x        = r_dot;
  assign pixel_y        = r_line;
  assign pixel_valid    = r_valid;
  assign vblank_start   = r_vblank;
  assign frame_odd      = r_frame_odd;

endmodule

// File: tb/tb_ntsc_timing_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ntsc_timing_sequencer
//
// Directed bench. u_a uses the default NES geometry, for the horizontal
// decode, hold behaviour and mid-line reset. u_b keeps the 341-dot line but
// uses 16 lines per frame with 2 active lines, so that whole frames stay
// short. With this geometry the vertical layout is:
//   picture 0-1, blank 2-5, vsync 6-8, blank 9-15, vblank_start at (3,1).
//   Frame length: 5456 dots, or 5455 dots for the short odd frame.
// ---------------------------------------------------------------------------
module tb_ntsc_timing_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] pic_col  = 6'h16;
  logic [5:0] back_col = 6'h0F;
  logic [2:0] emph_in  = 3'b101;

  // Instance A signals
  logic       rst_a = 1'b1, den_a = 1'b0, ren_a = 1'b0;
  logic       sync_a, burst_a, lum_a, chr_a, valid_a, vb_a, odd_a;
  logic [5:0] col_a;
  logic [2:0] emph_a;
  logic [8:0] px_a, py_a;

  // Instance B signals
  logic       rst_b = 1'b1, den_b = 1'b0, ren_b = 1'b0;
  logic       sync_b, burst_b, lum_b, chr_b, valid_b, vb_b, odd_b;
  logic [5:0] col_b;
  logic [2:0] emph_b;
  logic [8:0] px_b, py_b;

  ntsc_timing_sequencer u_a (
    .clock(clock), .reset(rst_a), .dot_EN(den_a), .render_EN(ren_a),
    .picture_colour(pic_col), .backdrop_colour(back_col), .emphasis_in(emph_in),
    .sync_EN(sync_a), .colorBurst_EN(burst_a), .luminance_EN(lum_a),
    .chrominance_EN(chr_a), .pixelColour(col_a), .emphasis(emph_a),
    .pixel_x(px_a), .pixel_y(py_a), .pixel_valid(valid_a),
    .vblank_start(vb_a), .frame_odd(odd_a)
  );

  ntsc_timing_sequencer #(.LINES_PER_FRAME(16), .ACTIVE_LINES(2)) u_b (
    .clock(clock), .reset(rst_b), .dot_EN(den_b), .render_EN(ren_b),
    .picture_colour(pic_col), .backdrop_colour(back_col), .emphasis_in(emph_in),
    .sync_EN(sync_b), .colorBurst_EN(burst_b), .luminance_EN(lum_b),
    .chrominance_EN(chr_b), .pixelColour(col_b), .emphasis(emph_b),
    .pixel_x(px_b), .pixel_y(py_b), .pixel_valid(valid_b),
    .vblank_start(vb_b), .frame_odd(odd_b)
  );

  int checks = 0;
  int errors = 0;

  // Per-frame statistics gathered on instance B
  int n_vb, vb_x, vb_y, n_sync7, n_sync7_serr, n_lum12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic dot_a();
    den_a = 1'b1;
    @(posedge clock);
    #1;
    den_a = 1'b0;
  endtask

  task automatic dot_b();
    den_b = 1'b1;
    @(posedge clock);
    #1;
    den_b = 1'b0;
  endtask

  task automatic advance_a(input int n);
    for (int i = 0; i < n; i++) dot_a();
  endtask

  // Runs instance B from (0,0) until it returns to (0,0) or the bound expires.
  // When drop_render is set, render_EN is pulled low just as dot 339 of
  // line 15 is being output.
  task automatic run_frame_b(input bit drop_render, output int n);
    n = 0;
    n_vb = 0; vb_x = -1; vb_y = -1;
    n_sync7 = 0; n_sync7_serr = 0; n_lum12 = 0;
    for (int i = 0; i < 7000; i++) begin
      if (drop_render && px_b == 9'd339 && py_b == 9'd15) ren_b = 1'b0;
      dot_b();
      n++;
      if (vb_b) begin
        n_vb++;
        vb_x = int'(px_b);
        vb_y = int'(py_b);
      end
      if (py_b == 9'd7 && sync_b) begin
        n_sync7++;
        if (px_b >= 9'd276 && px_b <= 9'd300) n_sync7_serr++;
      end
      if (py_b == 9'd12 && lum_b) n_lum12++;
      if (px_b == 9'd0 && py_b == 9'd0) break;
    end
  endtask

  int n_valid, n_pic_bad, n_bord_bad, n_black_bad, n_pos_bad, n_overlap;
  int n_sync, first_sync, n_burst, first_burst;
  int flen;

  initial begin
    // ---------------- Instance A: reset with dot_EN high ----------------
    rst_a = 1'b1; den_a = 1'b1;
    rst_b = 1'b1; den_b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs",
        {23'd0, sync_a, burst_a, lum_a, chr_a, valid_a, vb_a, odd_a, |col_a, |emph_a},
        32'd0);
    chk("reset_x", px_a, 0);
    chk("reset_y", py_a, 0);
    rst_a = 1'b0; den_a = 1'b0;
    rst_b = 1'b0; den_b = 1'b0;

    // First dot after reset
    dot_a();
    chk("first_dot_x", px_a, 1);
    chk("first_dot_valid", valid_a, 1);
    chk("first_dot_colour", col_a, 6'h16);
    chk("first_dot_emph", emph_a, 3'b101);

    // Outputs hold between dot pulses even when inputs change
    pic_col = 6'h2A;
    repeat (2) @(posedge clock);
    #1;
    chk("hold_x", px_a, 1);
    chk("hold_colour", col_a, 6'h16);
    pic_col = 6'h16;

    // ---------------- Instance A: measure line 10 ----------------
    advance_a(10 * 341 - 1);
    n_valid = 0; n_pic_bad = 0; n_bord_bad = 0; n_black_bad = 0;
    n_pos_bad = 0; n_overlap = 0;
    n_sync = 0; first_sync = -1; n_burst = 0; first_burst = -1;
    for (int d = 0; d < 341; d++) begin
      if (d > 0) dot_a();
      if (int'(px_a) != d || py_a != 9'd10) n_pos_bad++;
      if (valid_a) n_valid++;
      if (d < 256 && (col_a != 6'h16 || !lum_a || !chr_a || emph_a != 3'b101)) n_pic_bad++;
      if (d >= 256 && d <= 266 && (col_a != 6'h0F || valid_a || !lum_a)) n_bord_bad++;
      if (((d >= 267 && d <= 275) || (d >= 301 && d <= 304) || (d >= 320 && d <= 325)) &&
          (sync_a || burst_a || lum_a || chr_a || col_a != 6'd0)) n_black_bad++;
      if (sync_a) begin
        if (n_sync == 0) first_sync = d;
        n_sync++;
      end
      if (burst_a) begin
        if (n_burst == 0) first_burst = d;
        n_burst++;
      end
      if ((sync_a && burst_a) || (lum_a && (sync_a || burst_a))) n_overlap++;
    end
    chk("l10_position", n_pos_bad, 0);
    chk("l10_valid_count", n_valid, 256);
    chk("l10_picture_colour", n_pic_bad, 0);
    chk("l10_border_colour", n_bord_bad, 0);
    chk("l10_black_level", n_black_bad, 0);
    chk("l10_sync_count", n_sync, 25);
    chk("l10_sync_first", first_sync, 276);
    chk("l10_burst_count", n_burst, 15);
    chk("l10_burst_first", first_burst, 305);
    chk("l10_overlap", n_overlap, 0);

    // ---------------- Instance A: reset at line 100, dot 150 ----------------
    advance_a(1 + 89 * 341 + 150);
    chk("pre_reset_y", py_a, 100);
    chk("pre_reset_x", px_a, 150);
    rst_a = 1'b1; den_a = 1'b1;
    @(posedge clock);
    #1;
    rst_a = 1'b0; den_a = 1'b0;
    chk("midreset_x", px_a, 0);
    chk("midreset_y", py_a, 0);
    chk("midreset_odd", odd_a, 0);
    dot_a();
    chk("after_midreset_x", px_a, 1);
    chk("after_midreset_y", py_a, 0);
    chk("after_midreset_pic", {29'd0, valid_a, lum_a, chr_a}, 32'd7);

    // ---------------- Instance B: whole frames ----------------
    ren_b = 1'b0;
    run_frame_b(1'b0, flen);
    chk("f1_len", flen, 5456);
    chk("f1_odd", odd_b, 1);
    chk("f1_vblank_count", n_vb, 1);
    chk("f1_vblank_y", vb_y, 3);
    chk("f1_vblank_x", vb_x, 1);
    chk("f1_vsync_line_sync", n_sync7, 316);
    chk("f1_vsync_serration", n_sync7_serr, 0);
    chk("f1_blank_line_lum", n_lum12, 0);

    run_frame_b(1'b0, flen);
    chk("f2_len_odd_norender", flen, 5456);
    chk("f2_odd", odd_b, 0);

    ren_b = 1'b1;
    run_frame_b(1'b0, flen);
    chk("f3_len_even_render", flen, 5456);
    chk("f3_odd", odd_b, 1);

    run_frame_b(1'b0, flen);
    chk("f4_len_odd_render", flen, 5455);
    chk("f4_odd", odd_b, 0);
    chk("f4_vblank_count", n_vb, 1);

    run_frame_b(1'b0, flen);
    chk("f5_len_even_render", flen, 5456);
    chk("f5_odd", odd_b, 1);

    // Odd frame with render_EN dropped exactly at the skip decision dot
    run_frame_b(1'b1, flen);
    chk("f6_len_render_dropped", flen, 5456);
    chk("f6_odd", odd_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
